key_schedule_ctrl: RTL and testbench

AES-128 key-expansion sequencer that sits directly downstream of g_function and drives it.
- Accepts a 128-bit cipher key and emits round keys 0..10 in order over a valid/ready stream.
- For each new round it hands the last word of the previous round key, plus the round index, to the g_function stage, waits for its done, then XOR-chains the four new words.
- Feeds the round-key store / cipher datapath.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/key_schedule_ctrl_if.sv | 36 +++
 rtl/key_schedule_ctrl_key_word_xor.sv | 22 ++
 rtl/key_schedule_ctrl.sv | 122 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion types, constants and the FSM encoding of the
// key schedule sequencer.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;
    typedef logic [3:0]   round_t;

    localparam round_t NUM_ROUNDS = 4'd10;

    // Round constants for rounds 1..10, shared with g_function.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EMIT,
        KS_G_REQ,
        KS_G_WAIT
    } ks_state_t;

    function automatic logic [7:0] rcon(input round_t r);
        logic [7:0] value;
        value = 8'h00;
        if (r >= 4'd1 && r <= NUM_ROUNDS) begin
            value = RCON[r - 4'd1];
        end
        return value;
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Key input stream, g_function request/response bus and round-key output
// stream of the key schedule sequencer.
interface key_schedule_ctrl_if;
    import aes_pkg::*;

    logic   key_valid;
    logic   key_ready;
    rkey_t  key_in;

    logic   g_enable;
    word_t  g_word;
    round_t g_round;
    word_t  g_result;
    logic   g_done;

    logic   rk_valid;
    logic   rk_ready;
    round_t rk_round;
    rkey_t  rk_data;

    logic   busy;
    logic   error;

    modport master (
        input  key_valid, key_in, g_result, g_done, rk_ready,
        output key_ready, g_enable, g_word, g_round,
               rk_valid, rk_round, rk_data, busy, error
    );

    modport slave (
        output key_valid, key_in, g_result, g_done, rk_ready,
        input  key_ready, g_enable, g_word, g_round,
               rk_valid, rk_round, rk_data, busy, error
    );

endinterface

// File: rtl/key_schedule_ctrl_key_word_xor.sv
// XOR chain that turns the previous round key and the g_function result into
// the next round key.
module key_word_xor
    import aes_pkg::*;
(
    input  rkey_t prev,
    input  word_t g_result,
    output rkey_t next
);

    word_t w4;
    word_t w5;
    word_t w6;
    word_t w7;

    assign w4   = prev[127:96] ^ g_result;
    assign w5   = w4 ^ prev[95:64];
    assign w6   = w5 ^ prev[63:32];
    assign w7   = w6 ^ prev[31:0];
    assign next = {w4, w5, w6, w7};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-expansion sequencer: streams round keys 0..10, using an external
// g_function stage for the non-linear word of each new round.
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int G_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    key_schedule_ctrl_if.master bus
);

    // The counter starts at 0 in the first wait cycle, so this terminal value
    // raises error exactly G_TIMEOUT cycles after the g_enable pulse.
    localparam logic [7:0] TO_LAST = 8'(G_TIMEOUT - 2);

    ks_state_t  state;
    ks_state_t  state_next;
    rkey_t      rk_reg;
    rkey_t      rk_next;
    round_t     round;
    logic [7:0] to_cnt;
    logic       busy_q;
    logic       error_q;

    logic key_accept;
    logic last_taken;
    logic g_timeout;

    key_word_xor u_key_word_xor (
        .prev     (rk_reg),
        .g_result (bus.g_result),
        .next     (rk_next)
    );

    assign key_accept = (state == KS_IDLE) && bus.key_valid;
    assign last_taken = (state == KS_EMIT) && bus.rk_ready && (round == NUM_ROUNDS);
    assign g_timeout  = (state == KS_G_WAIT) && !bus.g_done && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= KS_IDLE;
            rk_reg  <= '0;
            round   <= '0;
            to_cnt  <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            if (key_accept) begin
                rk_reg  <= bus.key_in;
                round   <= '0;
                error_q <= 1'b0;
                busy_q  <= 1'b1;
            end
            if (last_taken) begin
                busy_q <= 1'b0;
            end
            if (state == KS_G_REQ) begin
                to_cnt <= '0;
            end
            if (state == KS_G_WAIT) begin
                to_cnt <= to_cnt + 8'd1;
                if (bus.g_done) begin
                    rk_reg <= rk_next;
                    round  <= round + 4'd1;
                end
            end
            // rk_reg is deliberately kept on timeout for post-mortem inspection.
            if (g_timeout) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.key_ready = 1'b0;
        bus.rk_valid  = 1'b0;
        bus.rk_data   = '0;
        bus.rk_round  = '0;
        bus.g_enable  = 1'b0;
        bus.g_word    = '0;
        bus.g_round   = '0;
        bus.busy      = busy_q;
        bus.error     = error_q;
        case (state)
            KS_IDLE: begin
                bus.key_ready = 1'b1;
                if (bus.key_valid) begin
                    state_next = KS_EMIT;
                end
            end
            KS_EMIT: begin
                bus.rk_valid = 1'b1;
                bus.rk_data  = rk_reg;
                bus.rk_round = round;
                if (bus.rk_ready) begin
                    state_next = (round == NUM_ROUNDS) ? KS_IDLE : KS_G_REQ;
                end
            end
            KS_G_REQ: begin
                bus.g_enable = 1'b1;
                bus.g_word   = rk_reg[31:0];
                bus.g_round  = round + 4'd1;
                state_next   = KS_G_WAIT;
            end
            KS_G_WAIT: begin
                bus.g_word  = rk_reg[31:0];
                bus.g_round = round + 4'd1;
                if (bus.g_done) begin
                    state_next = KS_EMIT;
                end else if (to_cnt == TO_LAST) begin
                    state_next = KS_IDLE;
                end
            end
            default: state_next = KS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl with a behavioural g_function that
// answers a configurable number of cycles after each request.
module tb_key_schedule_ctrl;
    import aes_pkg::*;

    localparam rkey_t KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam rkey_t KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    key_schedule_ctrl_if ifc ();

    key_schedule_ctrl #(.G_TIMEOUT(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     g_delay  = 3;
    bit     g_mute   = 1'b0;
    int     spur_req = 0;
    int     spur_done = 0;
    bit     g1_seen  = 1'b0;
    word_t  g1_word  = '0;
    word_t  g1_result = '0;
    rkey_t  exp_rk  [11];
    rkey_t  hs_data [11];
    int     hs_cyc  [11];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from the GF(2^8) inverse and the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic word_t g_ref(input word_t w, input round_t r);
        word_t      rot;
        logic [7:0] rc;
        rot = {w[23:0], w[31:24]};
        rc  = 8'h01;
        for (int i = 1; i < int'(r); i++) rc = xtime(rc);
        return {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    task automatic build_expected(input rkey_t key);
        word_t w4, w5, w6, w7;
        rkey_t prev;
        exp_rk[0] = key;
        for (int r = 1; r <= 10; r++) begin
            prev = exp_rk[r-1];
            w4 = prev[127:96] ^ g_ref(prev[31:0], 4'(r));
            w5 = w4 ^ prev[95:64];
            w6 = w5 ^ prev[63:32];
            w7 = w6 ^ prev[31:0];
            exp_rk[r] = {w4, w5, w6, w7};
        end
    endtask

    // Behavioural g_function; also emits unsolicited g_done pulses on request.
    initial begin
        word_t  w;
        round_t r;
        word_t  res;
        ifc.g_done   = 1'b0;
        ifc.g_result = '0;
        forever begin
            @(negedge clk);
            if (ifc.g_enable && !g_mute) begin
                w   = ifc.g_word;
                r   = ifc.g_round;
                res = g_ref(w, r);
                if (r == 4'd1) begin
                    g1_seen = 1'b1; g1_word = w; g1_result = res;
                end
                repeat (g_delay) @(posedge clk);
                #1;
                ifc.g_result = res;
                ifc.g_done   = 1'b1;
                if (ifc.busy) begin
                    check_eq("g_word_held", 128'(ifc.g_word), 128'(w));
                    check_eq("g_round_held", 128'(ifc.g_round), 128'(r));
                end
                @(posedge clk);
                #1;
                ifc.g_done   = 1'b0;
                ifc.g_result = '0;
            end else if (spur_req != spur_done) begin
                @(posedge clk);
                #1;
                ifc.g_result = $urandom;
                ifc.g_done   = 1'b1;
                @(posedge clk);
                #1;
                ifc.g_done   = 1'b0;
                spur_done++;
            end
        end
    end

    task automatic send_key(input rkey_t key);
        @(negedge clk);
        ifc.rk_ready  = 1'b0;
        ifc.key_in    = key;
        ifc.key_valid = 1'b1;
        check_eq("key_ready_idle", 128'(ifc.key_ready), 128'(1));
        @(posedge clk);
        #1 ifc.key_valid = 1'b0;
    endtask

    // Consumes nrounds round keys with rk_ready high pct% of the time.
    task automatic drain(input rkey_t key, input int pct, input int nrounds, input bit hold2);
        int     idx;
        int     cyc;
        bit     stalled;
        rkey_t  last_d;
        round_t last_r;
        idx = 0; cyc = 0; stalled = 1'b0; last_d = '0; last_r = '0;
        build_expected(key);
        while (idx < nrounds && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check_eq("stall_valid", 128'(ifc.rk_valid), 128'(1));
                check_eq("stall_data", ifc.rk_data, last_d);
                check_eq("stall_round", 128'(ifc.rk_round), 128'(last_r));
            end
            if (hold2 && idx >= 4 && !ifc.key_valid) begin
                ifc.key_in    = KEY2;
                ifc.key_valid = 1'b1;
            end
            if (ifc.key_valid && ifc.busy)
                check_eq("key_ready_busy", 128'(ifc.key_ready), 128'(0));
            ifc.rk_ready = (int'($urandom_range(0, 99)) < pct);
            if (ifc.rk_valid && ifc.rk_ready) begin
                check_eq("rk_round", 128'(ifc.rk_round), 128'(idx));
                check_eq("rk_data", ifc.rk_data, exp_rk[idx]);
                hs_data[idx] = ifc.rk_data;
                hs_cyc[idx]  = cyc;
                idx++;
                stalled = 1'b0;
            end else if (ifc.rk_valid) begin
                check_eq("g_enable_stall", 128'(ifc.g_enable), 128'(0));
                stalled = 1'b1;
                last_d  = ifc.rk_data;
                last_r  = ifc.rk_round;
            end else begin
                stalled = 1'b0;
            end
        end
        check_eq("drain_count", 128'(idx), 128'(nrounds));
    endtask

    initial begin
        bit found;
        ifc.key_valid = 1'b0;
        ifc.key_in    = '0;
        ifc.rk_ready  = 1'b0;

        #2;
        check_eq("rst_key_ready", 128'(ifc.key_ready), 128'(1));
        check_eq("rst_rk_valid", 128'(ifc.rk_valid), 128'(0));
        check_eq("rst_busy", 128'(ifc.busy), 128'(0));
        check_eq("rst_error", 128'(ifc.error), 128'(0));
        check_eq("rst_g_enable", 128'(ifc.g_enable), 128'(0));
        check_eq("rst_rk_data", ifc.rk_data, 128'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // FIPS-197 vector, no backpressure.
        send_key(KEY1);
        drain(KEY1, 100, 11, 1'b0);
        check_eq("fips_rk0", hs_data[0], KEY1);
        check_eq("fips_rk1", hs_data[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("fips_rk10", hs_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("g1_seen", 128'(g1_seen), 128'(1));
        check_eq("g1_word", 128'(g1_word), 128'h09cf4f3c);
        check_eq("g1_result", 128'(g1_result), 128'h8b84eb01);
        check_eq("first_latency", 128'(hs_cyc[0]), 128'(1));
        for (int k = 1; k <= 10; k++)
            check_eq("round_spacing", 128'(hs_cyc[k] - hs_cyc[k-1]), 128'(2 + g_delay));
        @(negedge clk);
        check_eq("done_busy", 128'(ifc.busy), 128'(0));
        check_eq("done_key_ready", 128'(ifc.key_ready), 128'(1));

        // Backpressure.
        send_key(KEY1);
        drain(KEY1, 30, 11, 1'b0);

        // g_done never arrives.
        g_mute = 1'b1;
        send_key(KEY1);
        drain(KEY1, 100, 1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifc.g_enable) found = 1'b1;
        end
        check_eq("to_g_enable_seen", 128'(found), 128'(1));
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 63) begin
                check_eq("to_error_early", 128'(ifc.error), 128'(0));
                check_eq("to_busy_early", 128'(ifc.busy), 128'(1));
            end
            if (k == 64) begin
                check_eq("to_error", 128'(ifc.error), 128'(1));
                check_eq("to_busy", 128'(ifc.busy), 128'(0));
                check_eq("to_key_ready", 128'(ifc.key_ready), 128'(1));
            end
        end
        g_mute = 1'b0;
        send_key(KEY1);
        @(negedge clk);
        check_eq("to_error_cleared", 128'(ifc.error), 128'(0));
        drain(KEY1, 100, 11, 1'b0);

        // g_done on the very cycle the timeout would fire.
        g_delay = 63;
        send_key(KEY2);
        drain(KEY2, 100, 11, 1'b0);
        check_eq("late_done_error", 128'(ifc.error), 128'(0));
        g_delay = 3;

        // Second key held during the first key's schedule.
        send_key(KEY1);
        drain(KEY1, 100, 11, 1'b1);
        @(negedge clk);
        check_eq("hold_key_ready", 128'(ifc.key_ready), 128'(1));
        check_eq("hold_busy", 128'(ifc.busy), 128'(0));
        @(posedge clk);
        #1 ifc.key_valid = 1'b0;
        drain(KEY2, 100, 11, 1'b0);
        check_eq("key2_rk10", hs_data[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset while waiting on g_function in round 6.
        @(negedge clk);
        send_key(KEY1);
        drain(KEY1, 100, 6, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (ifc.g_enable && ifc.g_round == 4'd6) found = 1'b1;
        end
        check_eq("r6_g_enable_seen", 128'(found), 128'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_key_ready", 128'(ifc.key_ready), 128'(1));
        check_eq("mid_rst_rk_valid", 128'(ifc.rk_valid), 128'(0));
        check_eq("mid_rst_busy", 128'(ifc.busy), 128'(0));
        check_eq("mid_rst_g_word", 128'(ifc.g_word), 128'(0));
        check_eq("mid_rst_g_round", 128'(ifc.g_round), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_rk_valid", 128'(ifc.rk_valid), 128'(0));
            check_eq("post_rst_key_ready", 128'(ifc.key_ready), 128'(1));
            check_eq("post_rst_busy", 128'(ifc.busy), 128'(0));
        end

        // Unsolicited g_done in IDLE and in EMIT.
        spur_req++;
        repeat (4) @(negedge clk);
        check_eq("spur_idle_key_ready", 128'(ifc.key_ready), 128'(1));
        check_eq("spur_idle_rk_valid", 128'(ifc.rk_valid), 128'(0));
        check_eq("spur_idle_busy", 128'(ifc.busy), 128'(0));
        send_key(KEY1);
        spur_req++;
        repeat (4) @(negedge clk);
        check_eq("spur_emit_valid", 128'(ifc.rk_valid), 128'(1));
        check_eq("spur_emit_round", 128'(ifc.rk_round), 128'(0));
        check_eq("spur_emit_data", ifc.rk_data, KEY1);
        check_eq("spur_emit_g_enable", 128'(ifc.g_enable), 128'(0));
        drain(KEY1, 100, 11, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
